// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-file write-back definitions
package wb_arbiter_pkg;

    localparam int RegNumLog2 = 5;

    typedef logic [31:0]           RegBus;
    typedef logic [RegNumLog2-1:0] RegAddrBus;

    localparam logic  WriteEnable        = 1'b1;
    localparam logic  RstEnable          = 1'b1;
    localparam RegBus ZeroWord           = 32'h0000_0000;
    localparam int    WbFifoDepthDefault = 2;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - multi-cycle result buffer with kill and hazard compares
module wb_result_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WbFifoDepthDefault,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  RegAddrBus     push_addr,
    input  RegBus         push_data,
    input  logic          pop,
    input  logic          kill_en,
    input  RegAddrBus     kill_addr,
    input  RegAddrBus     rd_addr1,
    input  RegAddrBus     rd_addr2,
    output logic          hazard1,
    output logic          hazard2,
    output logic          head_occ,
    output logic          head_valid,
    output RegAddrBus     head_addr,
    output RegBus         head_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] vld;
    RegAddrBus        addr_q [DEPTH];
    RegBus            data_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // vld is cleared on pop, so vld alone marks occupied-and-valid slots
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            vld    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && vld[i] && (addr_q[i] == kill_addr)) begin
                    vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (push) begin
                vld[wr_ptr]    <= 1'b1;
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (rd_addr1 != '0) && (addr_q[i] == rd_addr1)) hazard1 = 1'b1;
            if (vld[i] && (rd_addr2 != '0) && (addr_q[i] == rd_addr2)) hazard2 = 1'b1;
        end
    end

    assign head_occ   = (count != '0);
    assign head_valid = vld[rd_ptr];
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter (optional WB_MC_BYPASS_EN)
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = WbFifoDepthDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_waddr,
    input  logic [31:0] mc_wdata,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        stall_req,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic          pipe_sel;
    logic          fifo_sel;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          not_full;
    logic          head_occ;
    logic          head_valid;
    RegAddrBus     head_addr;
    RegBus         head_data;
    logic [CW-1:0] count;
    logic          fifo_haz1;
    logic          fifo_haz2;

    assign pipe_sel = pipe_we && (pipe_waddr != '0);
    assign fifo_sel = !pipe_sel && head_occ && head_valid;
    assign not_full = (count < FULL);

`ifdef WB_MC_BYPASS_EN
    assign bypass = (count == '0) && !pipe_sel && mc_valid && (mc_waddr != '0);
`else
    assign bypass = 1'b0;
`endif

    // killed heads drain silently even while the pipeline owns the port
    assign pop  = head_occ && (!head_valid || fifo_sel);
    assign push = mc_valid && not_full && (mc_waddr != '0) && !bypass
                  && !(pipe_sel && (mc_waddr == pipe_waddr));

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (mc_waddr),
        .push_data  (mc_wdata),
        .pop        (pop),
        .kill_en    (pipe_sel),
        .kill_addr  (pipe_waddr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .hazard1    (fifo_haz1),
        .hazard2    (fifo_haz2),
        .head_occ   (head_occ),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count)
    );

    always_comb begin
        we        = 1'b0;
        waddr     = '0;
        wdata     = ZeroWord;
        mc_ready  = 1'b0;
        stall_req = 1'b0;
        hazard1   = 1'b0;
        hazard2   = 1'b0;
        if (rst != RstEnable) begin
            mc_ready  = not_full;
            stall_req = (count == FULL);
            hazard1   = fifo_haz1;
            hazard2   = fifo_haz2;
            if (pipe_sel) begin
                we    = WriteEnable;
                waddr = pipe_waddr;
                wdata = pipe_wdata;
            end else if (fifo_sel) begin
                we    = WriteEnable;
                waddr = head_addr;
                wdata = head_data;
            end else if (bypass) begin
                we    = WriteEnable;
                waddr = mc_waddr;
                wdata = mc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter (honours WB_MC_BYPASS_EN)
module tb_wb_arbiter;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_waddr   (mc_waddr),
        .mc_wdata   (mc_wdata),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .stall_req  (stall_req),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          alive;
    } ment_t;

    typedef struct {
        logic [37:0] wport;
        logic [3:0]  status;
    } exp_t;

    ment_t mq[$];
    exp_t  expq[$];
    int    n_pass = 0;
    int    n_checks = 0;

    // Reference: buffered results as a list of {addr, data, alive}, oldest first
    task automatic cyc(input bit r, input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
        exp_t  e;
        bit    full, psel, fwr, byp, pop_it, h1, h2;
        logic  ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        @(posedge clk);
        #1;
        rst = r; pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
        mc_valid = mv; mc_waddr = ma; mc_wdata = md; rd_addr1 = r1; rd_addr2 = r2;
        if (r) begin
            e.wport  = '0;
            e.status = '0;
            mq.delete();
        end else begin
            full = (mq.size() == D);
            h1 = 0; h2 = 0;
            foreach (mq[i]) begin
                if (mq[i].alive && r1 != 0 && mq[i].a == r1) h1 = 1;
                if (mq[i].alive && r2 != 0 && mq[i].a == r2) h2 = 1;
            end
            psel = pw && (pa != 0);
            fwr  = !psel && mq.size() > 0 && mq[0].alive;
            byp  = 0;
`ifdef WB_MC_BYPASS_EN
            byp  = (mq.size() == 0) && !psel && mv && (ma != 0);
`endif
            ew = 0; ea = 0; ed = 0;
            if (psel) begin ew = 1; ea = pa; ed = pd; end
            else if (fwr) begin ew = 1; ea = mq[0].a; ed = mq[0].d; end
            else if (byp) begin ew = 1; ea = ma; ed = md; end
            e.wport  = {ew, ea, ed};
            e.status = {!full, full, h1, h2};
            pop_it = mq.size() > 0 && (!mq[0].alive || fwr);
            if (psel) foreach (mq[i]) if (mq[i].a == pa) mq[i].alive = 0;
            if (pop_it) void'(mq.pop_front());
            if (mv && !full && ma != 0 && !byp && !(psel && ma == pa))
                mq.push_back('{a: ma, d: md, alive: 1});
        end
        expq.push_back(e);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cyc(0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_checks++;
                if ({we, waddr, wdata} === e.wport) n_pass++;
                else $display("FAIL wport t=%0t actual we/addr/data=%h required=%h",
                              $time, {we, waddr, wdata}, e.wport);
                n_checks++;
                if ({mc_ready, stall_req, hazard1, hazard2} === e.status) n_pass++;
                else $display("FAIL status t=%0t actual ready/stall/h1/h2=%b required=%b",
                              $time, {mc_ready, stall_req, hazard1, hazard2}, e.status);
            end
        end
    end

    initial begin
        rst = 1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        mc_valid = 0; mc_waddr = 0; mc_wdata = 0; rd_addr1 = 0; rd_addr2 = 0;
        // reset with a pending mc result
        cyc(1, 0, 0, 0, 1, 5, 32'h1111, 0, 0);
        cyc(1, 0, 0, 0, 1, 5, 32'h1111, 0, 0);
        idle(5, 0);
        // idle pipe, mc writes x5
        cyc(0, 0, 0, 0, 1, 5, 32'h12345678, 0, 0);
        idle(0, 0);
        idle(0, 0);
        // collision: pipe owns the port while x7, x8 arrive
        cyc(0, 1, 3, 32'h33, 1, 7, 32'h7, 7, 0);
        cyc(0, 1, 3, 32'h34, 1, 8, 32'h8, 7, 8);
        cyc(0, 1, 3, 32'h35, 1, 9, 32'h9, 7, 8);
        cyc(0, 1, 3, 32'h36, 0, 0, 0, 7, 8);
        idle(7, 8);
        idle(7, 8);
        idle(7, 8);
        // kill: buffered x9 overtaken by pipe x9
        cyc(0, 1, 3, 32'h37, 1, 9, 32'hAAAA, 9, 0);
        cyc(0, 1, 9, 32'hBBBB, 0, 0, 0, 9, 0);
        idle(9, 0);
        idle(9, 0);
        // x0 handling on both producers
        cyc(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
        idle(0, 0);
        // hazard while x4 is buffered
        cyc(0, 1, 3, 32'h38, 1, 4, 32'h44, 4, 0);
        cyc(0, 1, 3, 32'h39, 0, 0, 0, 4, 0);
        idle(4, 0);
        idle(4, 0);
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                5'($urandom_range(0, 9)), $urandom,
                ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 9)), $urandom,
                5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL drain actual pending=%0d required=0", expq.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Drives the single register-file write port (we/waddr/wdata) from two producers.
- Producer 1: the in-order MEM/WB pipeline path, which always has priority.
- Producer 2: a multi-cycle unit (mul/div/long load). Its results are buffered in a small FIFO and drained on free write slots.
- Also reports decode-stage operand hazards against pending buffered writes, and requests a pipeline stall when the buffer is full.

Parameters:
- FIFO_DEPTH, 2, number of multi-cycle result entries; power of two, >=2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- pipe_we  in  1  pipeline write request
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline write data
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  buffer can accept a result this cycle
- mc_waddr  in  5  multi-cycle destination register
- mc_wdata  in  32  multi-cycle result data
- rd_addr1  in  5  decode read address, operand 1
- rd_addr2  in  5  decode read address, operand 2
- hazard1  out  1  operand 1 has a pending buffered write
- hazard2  out  1  operand 2 has a pending buffered write
- stall_req  out  1  buffer full; upstream must insert a bubble
- we  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data

Behaviour:
- Reset (rst=1 at posedge): count, rd/wr pointers and all entry valids go to 0.
- While rst=1, all outputs are 0, including mc_ready and stall_req. Buffered entries are discarded on mid-operation reset.
- FIFO entry fields: {valid, addr[4:0], data[31:0]}. count = occupied slots, killed slots included.
- Write-port select (combinational, priority order):
  - (a) pipe_we=1 and pipe_waddr!=0: drive the pipe values.
  - (b) else head slot occupied and valid: drive the head entry; pop at posedge.
  - (c) else we=0, waddr=0, wdata=0.
- Killed head: an occupied head with valid=0 is popped silently in any cycle, even while (a) is selected.
- mc_ready = (count < FIFO_DEPTH). It is independent of mc_valid and of a same-cycle pop.
- stall_req = (count == FIFO_DEPTH).
- Enqueue condition: mc_valid and mc_ready and mc_waddr!=0. Enqueue writes the wr_ptr slot with valid=1.
- mc_waddr=0: the result is accepted (handshake completes) but discarded.
- Simultaneous push and pop are legal; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Drain order is FIFO (oldest first).
- Kill rule (pipeline write is younger, so it wins):
  - When (a) commits address A, every stored valid entry with addr A clears valid at that posedge.
  - A same-cycle incoming mc result with addr A is accepted and dropped.
- hazardN = (rd_addrN != 0) and (some occupied, valid entry has addr == rd_addrN). The same-cycle incoming mc result is excluded.
- Latency:
  - Pipeline path: 0 cycles (combinational through).
  - Multi-cycle path: >=1 cycle after acceptance.

Optional Feature:
- Macro: WB_MC_BYPASS_EN.
- When defined, and all of the following hold, the mc result drives we/waddr/wdata in the same cycle and is not enqueued:
  - count==0
  - no pipe write is selected
  - mc_valid=1 and mc_waddr!=0
  - The bypass is a 0-cycle path.
- When undefined, mc results always pass through the FIFO, with minimum 1-cycle latency.

Decomposition:
- Shared definitions file: RegBus(31:0), RegAddrBus(4:0), RegNumLog2, WriteEnable, RstEnable, ZeroWord. Add WbFifoDepthDefault there.
- Sub-module wb_result_fifo holds:
  - entry storage, pointers and count
  - the kill compare
  - the two hazard compare ports
- wb_arbiter keeps the port-select and bypass logic.

Test Plan:
- Reset: rst=1 for 2 cycles with mc_valid=1, mc_waddr=5 -> we=0, mc_ready=0; after release count=0 and nothing is written.
- Idle pipe, mc writes x5=0x12345678 at cycle N:
  - Without bypass: we=1, waddr=5, wdata=0x12345678 at cycle N+1.
  - With bypass: same at cycle N.
- Collision: pipe writes x3 every cycle while mc delivers x7=0x7, then x8=0x8:
  - After the second acceptance, stall_req=1 and mc_ready=0.
  - Two pipe bubbles then write x7, then x8, in order; stall_req returns to 0.
- Kill: buffer holds x9=0xAAAA (pipe busy); pipe writes x9=0xBBBB -> only 0xBBBB is ever written to x9; the entry pops silently; count reaches 0.
- x0: mc_waddr=0 is accepted (mc_ready=1) with no enqueue; pipe_we=1 with pipe_waddr=0 gives we=0.
- Hazard: buffer holds x4, rd_addr1=4, rd_addr2=0 -> hazard1=1, hazard2=0; after x4 drains, hazard1=0.
